// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the MIPS control units (single-cycle and multicycle).
// Holds the FSM state encoding, opcode/funct constants, ALU operation codes,
// instruction class encoding and PC source select codes.
// No ports: package only.
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

    // Multicycle FSM states; values are visible on the debug 'state' port
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_BRANCH = 3'd5,
        ST_JUMP   = 3'd6,
        ST_TRAP   = 3'd7
    } state_t;

    // ALU operation codes understood by the datapath ALU
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_NOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_t;

    // Instruction class captured in DECODE and used by the later states
    typedef enum logic [2:0] {
        CLS_NONE    = 3'd0,
        CLS_RTYPE   = 3'd1,
        CLS_IALU    = 3'd2,
        CLS_LOAD    = 3'd3,
        CLS_STORE   = 3'd4,
        CLS_BRANCH  = 3'd5,
        CLS_JUMP    = 3'd6,
        CLS_ILLEGAL = 3'd7
    } inst_class_t;

    // Width of the native ALU operation code
    localparam int ALU_OP_BITS = 3;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // PC source select
    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // Every class except R-type takes the sign-extended immediate as ALU B
    function automatic logic uses_immediate(inst_class_t cls);
        return (cls != CLS_RTYPE);
    endfunction

endpackage

// File: rtl/alu_decode.sv
// ---------------------------------------------------------------------------
// alu_decode
// Purely combinational opcode/funct decoder shared with the single-cycle unit.
// Produces the instruction class and the ALU controls for that instruction.
// Ports:
//   opcode  in  6  IR[31:26]
//   funct   in  6  IR[5:0]
//   cls     out 3  instruction class (inst_class_t encoding)
//   alu_op  out 3  ALU operation (alu_op_t encoding)
//   sign1   out 1  operand A treated as unsigned
//   sign2   out 1  operand B treated as unsigned
//   shift   out 1  use shamt as the shift operand
// ---------------------------------------------------------------------------
module alu_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] cls,
    output logic [2:0] alu_op,
    output logic       sign1,
    output logic       sign2,
    output logic       shift
);

    // Anything not matched below falls out as an illegal instruction.
    // The unsigned variants (addu/subu/sltu/addiu/sltiu) raise both
    // unsigned-operand flags; everything else is signed.
    always_comb begin
        cls    = CLS_ILLEGAL;
        alu_op = ALU_ADD;
        sign1  = 1'b0;
        sign2  = 1'b0;
        shift  = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                cls = CLS_RTYPE;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_ADDU: begin
                        alu_op = ALU_ADD;
                        sign1  = 1'b1;
                        sign2  = 1'b1;
                    end
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_SUBU: begin
                        alu_op = ALU_SUB;
                        sign1  = 1'b1;
                        sign2  = 1'b1;
                    end
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLTU: begin
                        alu_op = ALU_SLT;
                        sign1  = 1'b1;
                        sign2  = 1'b1;
                    end
                    FN_SLL: begin
                        alu_op = ALU_SLL;
                        shift  = 1'b1;
                    end
                    FN_SRL: begin
                        alu_op = ALU_SRL;
                        shift  = 1'b1;
                    end
                    default: cls = CLS_ILLEGAL;
                endcase
            end
            OP_LW: begin
                cls    = CLS_LOAD;
                alu_op = ALU_ADD;
            end
            OP_SW: begin
                cls    = CLS_STORE;
                alu_op = ALU_ADD;
            end
            OP_BEQ: begin
                cls    = CLS_BRANCH;
                alu_op = ALU_SUB;
            end
            OP_J: begin
                cls = CLS_JUMP;
            end
            OP_ADDI: begin
                cls    = CLS_IALU;
                alu_op = ALU_ADD;
            end
            OP_ADDIU: begin
                cls    = CLS_IALU;
                alu_op = ALU_ADD;
                sign1  = 1'b1;
                sign2  = 1'b1;
            end
            OP_ANDI: begin
                cls    = CLS_IALU;
                alu_op = ALU_AND;
            end
            OP_ORI: begin
                cls    = CLS_IALU;
                alu_op = ALU_OR;
            end
            OP_SLTI: begin
                cls    = CLS_IALU;
                alu_op = ALU_SLT;
            end
            OP_SLTIU: begin
                cls    = CLS_IALU;
                alu_op = ALU_SLT;
                sign1  = 1'b1;
                sign2  = 1'b1;
            end
            default: cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
// FSM-based control for a multicycle MIPS datapath with handshaked
// instruction and data memories, a memory wait timeout and sticky
// illegal-instruction / timeout trap flags.
// Parameters:
//   ALUOP_W     ALU operation output width (>= 3)
//   WAIT_LIMIT  max cycles to wait on a memory ready; 0 disables the timeout
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   opcode, funct            instruction fields IR[31:26], IR[5:0]
//   zero                     ALU zero flag (branch decision)
//   imem_ready, dmem_ready   memory handshakes
//   imem_req, ir_write, pc_write, pc_src        fetch / PC control
//   reg_write, reg_dst, mem_to_reg, alu_src_b   datapath muxes and write enable
//   alu_op, sign1, sign2, shift                 ALU controls
//   mem_read, mem_write      data memory strobes
//   illegal, timeout         sticky trap causes
//   state                    current FSM state for debug
// ---------------------------------------------------------------------------
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W    = 3,
    parameter int WAIT_LIMIT = 15
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               imem_req,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               sign1,
    output logic               sign2,
    output logic               shift,
    output logic               mem_read,
    output logic               mem_write,
    output logic               illegal,
    output logic               timeout,
    output logic [2:0]         state
);

    // Counter just wide enough to hold WAIT_LIMIT
    localparam int CNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_LIMIT);

    state_t           state_q;
    state_t           state_d;
    inst_class_t      cls_q;
    alu_op_t          alu_op_q;
    logic             sign1_q;
    logic             sign2_q;
    logic             shift_q;
    logic             illegal_q;
    logic             timeout_q;
    logic [CNT_W-1:0] wait_q;

    logic [2:0]       dec_cls;
    logic [2:0]       dec_alu_op;
    logic             dec_sign1;
    logic             dec_sign2;
    logic             dec_shift;

    logic             wait_expired;
    logic             waiting;
    logic             set_illegal;
    logic             set_timeout;

    alu_decode u_alu_decode (
        .opcode (opcode),
        .funct  (funct),
        .cls    (dec_cls),
        .alu_op (dec_alu_op),
        .sign1  (dec_sign1),
        .sign2  (dec_sign2),
        .shift  (dec_shift)
    );

    // The limit cycle itself still accepts a ready; only a missing ready
    // while the counter sits at the limit sends us to TRAP.
    assign wait_expired = (WAIT_LIMIT > 0) && (wait_q == CNT_LIMIT);
    assign waiting      = ((state_q == ST_FETCH) && !imem_ready) ||
                          ((state_q == ST_MEM)   && !dmem_ready);

    // Next-state selection plus all control outputs. Outputs follow the
    // registered state, so an async reset drops every strobe immediately.
    // The fetch strobes are also gated by rst so nothing fires while held
    // in reset even if imem_ready happens to be high.
    always_comb begin
        state_d     = state_q;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        imem_req    = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_SRC_SEQ;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_b   = 1'b0;
        alu_op      = '0;
        sign1       = 1'b0;
        sign2       = 1'b0;
        shift       = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;

        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready & ~rst;
                pc_write = imem_ready & ~rst;
                pc_src   = PC_SRC_SEQ;
                if (imem_ready) begin
                    state_d = ST_DECODE;
                end else if (wait_expired) begin
                    state_d     = ST_TRAP;
                    set_timeout = 1'b1;
                end
            end
            ST_DECODE: begin
                case (inst_class_t'(dec_cls))
                    CLS_RTYPE, CLS_IALU, CLS_LOAD, CLS_STORE: state_d = ST_EXEC;
                    CLS_BRANCH: state_d = ST_BRANCH;
                    CLS_JUMP:   state_d = ST_JUMP;
                    default: begin
                        state_d     = ST_TRAP;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            ST_EXEC: begin
                alu_op    = ALUOP_W'(alu_op_q);
                sign1     = sign1_q;
                sign2     = sign2_q;
                shift     = shift_q;
                alu_src_b = uses_immediate(cls_q);
                if ((cls_q == CLS_LOAD) || (cls_q == CLS_STORE)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                mem_read  = (cls_q == CLS_LOAD);
                mem_write = (cls_q == CLS_STORE);
                if (dmem_ready) begin
                    state_d = (cls_q == CLS_LOAD) ? ST_WB : ST_FETCH;
                end else if (wait_expired) begin
                    state_d     = ST_TRAP;
                    set_timeout = 1'b1;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (cls_q == CLS_RTYPE);
                mem_to_reg = (cls_q == CLS_LOAD);
                state_d    = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_op   = ALUOP_W'(ALU_SUB);
                pc_src   = PC_SRC_BRANCH;
                pc_write = zero;
                state_d  = ST_FETCH;
            end
            ST_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_SRC_JUMP;
                state_d  = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_TRAP;
            end
        endcase
    end

    // State register, decoded-instruction register, sticky flags and the
    // memory wait counter. The counter restarts whenever the state changes,
    // which covers every entry into FETCH or MEM, and only counts while one
    // of those states is stalled on its ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            cls_q     <= CLS_NONE;
            alu_op_q  <= ALU_ADD;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            shift_q   <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == ST_DECODE) begin
                cls_q    <= inst_class_t'(dec_cls);
                alu_op_q <= alu_op_t'(dec_alu_op);
                sign1_q  <= dec_sign1;
                sign2_q  <= dec_sign2;
                shift_q  <= dec_shift;
            end

            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
            if (set_timeout) begin
                timeout_q <= 1'b1;
            end

            if (state_d != state_q) begin
                wait_q <= '0;
            end else if (waiting && (wait_q != CNT_LIMIT)) begin
                wait_q <= wait_q + CNT_W'(1);
            end
        end
    end

    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
// Self-checking bench: a directed vector table, hand-written corner-case
// sequences and randomized instructions, all compared cycle by cycle against
// a behavioural model of the instruction timing and per-state outputs.
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

    localparam int LIMIT = 15;

    // Bench-side instruction kinds
    localparam int K_R   = 0;
    localparam int K_IMM = 1;
    localparam int K_LW  = 2;
    localparam int K_SW  = 3;
    localparam int K_BEQ = 4;
    localparam int K_J   = 5;
    localparam int K_BAD = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       imem_req, ir_write, pc_write, reg_write, reg_dst, mem_to_reg;
    logic       alu_src_b, sign1, sign2, shift, mem_read, mem_write;
    logic       illegal, timeout;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic [2:0] state;

    multicycle_control_unit #(.ALUOP_W(3), .WAIT_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .sign1(sign1), .sign2(sign2), .shift(shift), .mem_read(mem_read),
        .mem_write(mem_write), .illegal(illegal), .timeout(timeout),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] state;
        logic       imem_req;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_b;
        logic [2:0] alu_op;
        logic       sign1;
        logic       sign2;
        logic       shift;
        logic       mem_read;
        logic       mem_write;
        logic       illegal;
        logic       timeout;
    } obs_t;

    typedef struct {
        int         kind;
        logic [2:0] aluop;
        logic       uns;
        logic       sh;
    } dec_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         cycles;
        int         aluop;
    } vec_t;

    // {funct, alu op, unsigned, shift} for every legal R-type funct
    logic [10:0] rTab [11] = '{
        {6'b100000, 3'd0, 1'b0, 1'b0}, {6'b100001, 3'd0, 1'b1, 1'b0},
        {6'b100010, 3'd1, 1'b0, 1'b0}, {6'b100011, 3'd1, 1'b1, 1'b0},
        {6'b100100, 3'd2, 1'b0, 1'b0}, {6'b100101, 3'd3, 1'b0, 1'b0},
        {6'b100111, 3'd4, 1'b0, 1'b0}, {6'b101010, 3'd7, 1'b0, 1'b0},
        {6'b101011, 3'd7, 1'b1, 1'b0}, {6'b000000, 3'd5, 1'b0, 1'b1},
        {6'b000010, 3'd6, 1'b0, 1'b1}
    };
    // {opcode, alu op, unsigned} for the immediate ALU instructions
    logic [9:0] iTab [6] = '{
        {6'b001000, 3'd0, 1'b0}, {6'b001001, 3'd0, 1'b1},
        {6'b001100, 3'd2, 1'b0}, {6'b001101, 3'd3, 1'b0},
        {6'b001010, 3'd7, 1'b0}, {6'b001011, 3'd7, 1'b1}
    };

    int   checks = 0;
    int   passes = 0;
    logic illegalSeen = 1'b0;
    logic timeoutSeen = 1'b0;

    function automatic dec_t refDecode(input logic [5:0] op, input logic [5:0] fn);
        dec_t d;
        d.kind = K_BAD;
        d.aluop = 3'd0;
        d.uns = 1'b0;
        d.sh = 1'b0;
        if (op == 6'b000000) begin
            for (int i = 0; i < 11; i++) begin
                if (rTab[i][10:5] == fn) begin
                    d.kind = K_R;
                    d.aluop = rTab[i][4:2];
                    d.uns = rTab[i][1];
                    d.sh = rTab[i][0];
                end
            end
        end else if (op == 6'b100011) d.kind = K_LW;
        else if (op == 6'b101011) d.kind = K_SW;
        else if (op == 6'b000100) d.kind = K_BEQ;
        else if (op == 6'b000010) d.kind = K_J;
        else begin
            for (int i = 0; i < 6; i++) begin
                if (iTab[i][9:4] == op) begin
                    d.kind = K_IMM;
                    d.aluop = iTab[i][3:1];
                    d.uns = iTab[i][0];
                end
            end
        end
        return d;
    endfunction

    // Expected outputs for a given state code of the instruction
    function automatic obs_t expectFor(input int s, input dec_t d, input logic ir, input logic z);
        obs_t e = '0;
        e.state = 3'(s);
        e.illegal = illegalSeen;
        e.timeout = timeoutSeen;
        case (s)
            0: begin e.imem_req = 1'b1; e.ir_write = ir; e.pc_write = ir; end
            2: begin
                e.alu_op = d.aluop; e.sign1 = d.uns; e.sign2 = d.uns; e.shift = d.sh;
                e.alu_src_b = (d.kind != K_R);
            end
            3: begin e.mem_read = (d.kind == K_LW); e.mem_write = (d.kind == K_SW); end
            4: begin
                e.reg_write = 1'b1; e.reg_dst = (d.kind == K_R); e.mem_to_reg = (d.kind == K_LW);
            end
            5: begin e.alu_op = 3'd1; e.pc_src = 2'b01; e.pc_write = z; end
            6: begin e.pc_write = 1'b1; e.pc_src = 2'b10; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.state = state; o.imem_req = imem_req; o.ir_write = ir_write;
        o.pc_write = pc_write; o.pc_src = pc_src; o.reg_write = reg_write;
        o.reg_dst = reg_dst; o.mem_to_reg = mem_to_reg; o.alu_src_b = alu_src_b;
        o.alu_op = alu_op; o.sign1 = sign1; o.sign2 = sign2; o.shift = shift;
        o.mem_read = mem_read; o.mem_write = mem_write;
        o.illegal = illegal; o.timeout = timeout;
        return o;
    endfunction

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic ir, input logic dr);
        opcode = op; funct = fn; zero = z; imem_ready = ir; dmem_ready = dr;
    endtask

    task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic rbit();
        return ($urandom_range(0, 1) == 1);
    endfunction

    // Hold reset with every input high, then release just after an edge
    task automatic doReset();
        obs_t e = '0;
        rst = 1'b1;
        applyStimulus(6'($urandom), 6'($urandom), 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        e.imem_req = 1'b1;
        checkOutput("reset state", sample(), e);
        @(posedge clk);
        #1;
        rst = 1'b0;
        illegalSeen = 1'b0;
        timeoutSeen = 1'b0;
    endtask

    // Runs one instruction from its first FETCH cycle. The expected state
    // sequence is built from instruction kind and memory latencies; each
    // cycle is checked against the model's per-state outputs.
    task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int iDelay, input int dDelay, input string tag,
                            output int nonFetch, output int aluSeen, output int memCycles);
        dec_t d = refDecode(op, fn);
        int   q[$];
        int   trapKind = 0;
        int   fIdx = 0;
        int   mIdx = 0;
        logic ir, dr, zz;
        obs_t act;
        if (iDelay > LIMIT) begin
            repeat (LIMIT + 1) q.push_back(0);
            q.push_back(7); q.push_back(7);
            trapKind = 2;
        end else begin
            repeat (iDelay + 1) q.push_back(0);
            q.push_back(1);
            case (d.kind)
                K_R, K_IMM: begin q.push_back(2); q.push_back(4); end
                K_LW, K_SW: begin
                    q.push_back(2);
                    if (dDelay > LIMIT) begin
                        repeat (LIMIT + 1) q.push_back(3);
                        q.push_back(7); q.push_back(7);
                        trapKind = 2;
                    end else begin
                        repeat (dDelay + 1) q.push_back(3);
                        if (d.kind == K_LW) q.push_back(4);
                    end
                end
                K_BEQ: q.push_back(5);
                K_J:   q.push_back(6);
                default: begin q.push_back(7); q.push_back(7); trapKind = 1; end
            endcase
        end
        nonFetch = 0;
        aluSeen = 0;
        memCycles = 0;
        for (int i = 0; i < q.size(); i++) begin
            ir = (q[i] == 0) ? (fIdx == iDelay) : rbit();
            dr = (q[i] == 3) ? (mIdx == dDelay) : rbit();
            zz = (q[i] == 5) ? z : rbit();
            if (q[i] == 7 && trapKind == 1) illegalSeen = 1'b1;
            if (q[i] == 7 && trapKind == 2) timeoutSeen = 1'b1;
            applyStimulus(op, fn, zz, ir, dr);
            @(negedge clk);
            act = sample();
            checkOutput($sformatf("%s cycle %0d", tag, i), act, expectFor(q[i], d, ir, zz));
            if (act.state != 3'd0) nonFetch++;
            if (act.state == 3'd2 || act.state == 3'd5) aluSeen = int'(act.alu_op);
            if (act.mem_read || act.mem_write) memCycles++;
            if (q[i] == 0) fIdx++;
            if (q[i] == 3) mIdx++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vec_t vecs[$];
        int   nf, al, mc;
        vecs.push_back('{"add",   6'b000000, 6'b100000, 1'b0, 4, 0});
        vecs.push_back('{"addu",  6'b000000, 6'b100001, 1'b0, 4, 0});
        vecs.push_back('{"sub",   6'b000000, 6'b100010, 1'b0, 4, 1});
        vecs.push_back('{"subu",  6'b000000, 6'b100011, 1'b0, 4, 1});
        vecs.push_back('{"and",   6'b000000, 6'b100100, 1'b0, 4, 2});
        vecs.push_back('{"or",    6'b000000, 6'b100101, 1'b0, 4, 3});
        vecs.push_back('{"nor",   6'b000000, 6'b100111, 1'b0, 4, 4});
        vecs.push_back('{"slt",   6'b000000, 6'b101010, 1'b0, 4, 7});
        vecs.push_back('{"sltu",  6'b000000, 6'b101011, 1'b0, 4, 7});
        vecs.push_back('{"sll",   6'b000000, 6'b000000, 1'b0, 4, 5});
        vecs.push_back('{"srl",   6'b000000, 6'b000010, 1'b0, 4, 6});
        vecs.push_back('{"addi",  6'b001000, 6'b010101, 1'b0, 4, 0});
        vecs.push_back('{"addiu", 6'b001001, 6'b000111, 1'b0, 4, 0});
        vecs.push_back('{"andi",  6'b001100, 6'b111000, 1'b0, 4, 2});
        vecs.push_back('{"ori",   6'b001101, 6'b000001, 1'b0, 4, 3});
        vecs.push_back('{"slti",  6'b001010, 6'b110011, 1'b0, 4, 7});
        vecs.push_back('{"sltiu", 6'b001011, 6'b001100, 1'b0, 4, 7});
        vecs.push_back('{"lw",    6'b100011, 6'b000100, 1'b0, 5, 0});
        vecs.push_back('{"sw",    6'b101011, 6'b011000, 1'b0, 4, 0});
        vecs.push_back('{"beq z1", 6'b000100, 6'b000000, 1'b1, 3, 1});
        vecs.push_back('{"beq z0", 6'b000100, 6'b000000, 1'b0, 3, 1});
        vecs.push_back('{"j",     6'b000010, 6'b101010, 1'b0, 3, 0});

        doReset();

        foreach (vecs[k]) begin
            runInstr(vecs[k].op, vecs[k].fn, vecs[k].z, 0, 0, vecs[k].name, nf, al, mc);
            checkValue({vecs[k].name, " cycle count"}, nf + 1, vecs[k].cycles);
            checkValue({vecs[k].name, " alu_op"}, al, vecs[k].aluop);
        end

        // lw with data memory ready three cycles after MEM entry
        runInstr(6'b100011, 6'd0, 1'b0, 0, 3, "lw slow dmem", nf, al, mc);
        checkValue("lw slow mem_read cycles", mc, 4);
        checkValue("lw slow total cycles", nf + 1, 8);

        // Illegal opcode, then an illegal R-type funct; flag stays until reset
        runInstr(6'b111111, 6'd0, 1'b0, 0, 0, "illegal opcode", nf, al, mc);
        repeat (3) @(posedge clk);
        #1;
        checkValue("illegal sticky", int'(illegal), 1);
        checkValue("trap absorbing", int'(state), 7);
        doReset();
        checkValue("illegal cleared", int'(illegal), 0);
        runInstr(6'b000000, 6'b001000, 1'b0, 0, 0, "illegal funct", nf, al, mc);
        doReset();

        // Fetch timeout boundary: ready at count 15 wins, absent ready traps
        runInstr(6'b000000, 6'b100000, 1'b0, 15, 0, "imem ready at limit", nf, al, mc);
        checkValue("no timeout at limit", int'(timeout), 0);
        runInstr(6'b000000, 6'b100000, 1'b0, 16, 0, "imem timeout", nf, al, mc);
        checkValue("imem timeout flag", int'(timeout), 1);
        doReset();
        runInstr(6'b101011, 6'd0, 1'b0, 0, 15, "dmem ready at limit", nf, al, mc);
        runInstr(6'b101011, 6'd0, 1'b0, 0, 16, "dmem timeout", nf, al, mc);
        doReset();

        // Async reset in the middle of a stalled sw MEM cycle
        applyStimulus(6'b101011, 6'd0, 1'b0, 1'b1, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkValue("sw mem_write before rst", int'(mem_write), 1);
        #2 rst = 1'b1;
        #1;
        checkValue("mem_write after async rst", int'(mem_write), 0);
        checkValue("state after async rst", int'(state), 0);
        checkValue("ir_write held in rst", int'(ir_write), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        illegalSeen = 1'b0;
        timeoutSeen = 1'b0;

        // Randomized instruction stream
        for (int n = 0; n < 50; n++) begin
            logic [5:0] op, fn;
            int sel, iD, dD;
            sel = $urandom_range(0, 9);
            fn = 6'($urandom);
            if (sel <= 3) begin
                op = 6'd0;
                if ($urandom_range(0, 3) != 0) fn = rTab[$urandom_range(0, 10)][10:5];
            end else if (sel == 4) op = iTab[$urandom_range(0, 5)][9:4];
            else if (sel == 5) op = 6'b100011;
            else if (sel == 6) op = 6'b101011;
            else if (sel == 7) op = 6'b000100;
            else if (sel == 8) op = 6'b000010;
            else op = 6'($urandom);
            iD = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 16) : $urandom_range(0, 3);
            dD = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 16) : $urandom_range(0, 3);
            runInstr(op, fn, rbit(), iD, dD, $sformatf("random %0d", n), nf, al, mc);
            if (illegalSeen || timeoutSeen) doReset();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter ALUOP_W, default 3, meaning ALU operation code width (min 3).
REQ-002 SHALL have parameter WAIT_LIMIT, default 15, meaning max cycles waiting on a memory ready; 0 disables timeout.
REQ-003 SHALL have ports, clock and reset first:
  clk  in  1  sole clock, rising edge
  rst  in  1  asynchronous, active-high reset
  opcode  in  6  IR[31:26]
  funct  in  6  IR[5:0]
  zero  in  1  ALU zero flag
  imem_ready  in  1  instruction memory data valid
  dmem_ready  in  1  data memory access complete
  imem_req  out  1  instruction fetch request
  ir_write  out  1  load instruction register
  pc_write  out  1  update PC
  pc_src  out  2  00 PC+4, 01 branch target, 10 jump target
  reg_write  out  1  register file write enable
  reg_dst  out  1  1 = rd, 0 = rt
  mem_to_reg  out  1  1 = write-back from data memory
  alu_src_b  out  1  1 = sign-extended immediate
  alu_op  out  ALUOP_W  ALU operation (add 0, sub 1, and 2, or 3, nor 4, sll 5, srl 6, slt 7)
  sign1, sign2  out  1 each  unsigned-operand flags
  shift  out  1  shamt operand select
  mem_read, mem_write  out  1 each  data memory strobes
  illegal  out  1  sticky undefined-instruction flag
  timeout  out  1  sticky memory-timeout flag
  state  out  3  current state, for debug

Function
REQ-004 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, JUMP=6, TRAP=7.
REQ-005 FETCH SHALL assert imem_req and stay until imem_ready=1. In that cycle: ir_write=1, pc_write=1, pc_src=00; then -> DECODE.
REQ-006 DECODE SHALL register an instruction class plus alu_op/sign1/sign2/shift, using the existing single-cycle table. Next state:
  - lw, sw, R-type, addi, addiu, andi, ori, slti, sltiu -> EXEC
  - beq -> BRANCH
  - j -> JUMP
  - any other opcode, or an R-type funct outside {add, addu, sub, subu, and, or, nor, slt, sltu, sll, srl} -> TRAP, setting illegal.
REQ-007 EXEC SHALL drive the registered ALU controls, with alu_src_b=1 for every non-R class. lw/sw -> MEM; all others -> WB.
REQ-008 MEM SHALL hold mem_read (lw) or mem_write (sw) until dmem_ready=1. Then lw -> WB, sw -> FETCH.
REQ-009 WB SHALL assert reg_write for exactly one cycle: reg_dst=1 for R-type only, mem_to_reg=1 for lw only; then -> FETCH.
REQ-010 BRANCH SHALL drive alu_op=sub, pc_src=01, pc_write=zero (combinational on zero); then -> FETCH.
REQ-011 JUMP SHALL assert pc_write=1, pc_src=10 for one cycle; then -> FETCH.
REQ-012 TRAP SHALL be absorbing until rst, with all strobes (pc_write, ir_write, reg_write, mem_read, mem_write, imem_req) held 0.
REQ-013 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle without ready. If WAIT_LIMIT>0 and the count reaches WAIT_LIMIT without ready -> TRAP, setting timeout. A ready arriving in the limit cycle SHALL win.
REQ-014 Outputs not listed for a state SHALL be 0. Only pc_write (BRANCH) and ir_write/pc_write (FETCH) may depend combinationally on inputs.
REQ-015 Cycle counts SHALL be, with zero-wait memories: R/I-type 4, lw 5, sw 4, beq 3, j 3.

Reset
REQ-016 rst=1 SHALL asynchronously force: state=FETCH, wait counter=0, registered class/ALU controls=0, illegal=0, timeout=0. Every output then reads 0 except imem_req=1 and state=0.
REQ-017 Reset asserted mid-instruction (any state, including MEM with mem_write high) SHALL drop all strobes in the same cycle without waiting for a clock edge.

Structure
REQ-018 State encodings, opcode/funct constants, ALU op codes and class encoding SHALL live in shared package mips_ctrl_pkg, reused by the single-cycle unit.
REQ-019 Opcode/funct-to-ALU-control decoding SHALL be one combinational sub-module, alu_decode, instantiated once. The FSM and counter stay in the top.

Verification
REQ-020 add (opcode 000000, funct 100000), imem/dmem ready tied 1 -> states 0,1,2,4,0; reg_write=1, reg_dst=1 only in cycle 4; alu_op=0.
REQ-021 lw (100011) with dmem_ready raised 3 cycles after MEM entry -> mem_read high 4 cycles, then WB with mem_to_reg=1; total 8 cycles.
REQ-022 beq (000100), zero=1 -> pc_write=1, pc_src=01 in BRANCH. Repeat with zero=0 -> pc_write=0; both return to FETCH.
REQ-023 opcode 111111, and separately R-type funct 001000 -> TRAP after DECODE, illegal=1 and held; only rst clears it.
REQ-024 WAIT_LIMIT=15, imem_ready held 0 -> TRAP at count 15 with timeout=1. Ready asserted at count 15 -> DECODE, no timeout.
REQ-025 rst pulsed asynchronously mid-MEM of sw -> mem_write falls before the next clk edge, and state=FETCH.
